// File: rtl/cache_repl_engine_if.sv
// Access/victim bundle between the L2 controller and the replacement engine.
// Counter fields carry data only when REPL_STATS_EN is defined.
interface cache_repl_engine_if #(
    parameter int SETS  = 256,
    parameter int WAYS  = 4,
    parameter int SET_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
);
    logic [1:0]       policy;
    logic             access_valid;
    logic [SET_W-1:0] access_set;
    logic [WAY_W-1:0] access_way;
    logic             victim_req;
    logic [SET_W-1:0] victim_set;
    logic [WAYS-1:0]  valid_mask;
    logic             victim_valid;
    logic [WAY_W-1:0] victim_way;
    logic             busy;
    logic [31:0]      access_count;
    logic [31:0]      victim_count;

    modport master (
        output policy, access_valid, access_set, access_way,
        output victim_req, victim_set, valid_mask,
        input  victim_valid, victim_way, busy,
        input  access_count, victim_count
    );

    modport slave (
        input  policy, access_valid, access_set, access_way,
        input  victim_req, victim_set, valid_mask,
        output victim_valid, victim_way, busy,
        output access_count, victim_count
    );
endinterface

// File: rtl/cache_repl_engine.sv
// Per-set RANDOM/PLRU/LRU replacement engine with init sweep after reset.
// Optional saturating access/victim counters under REPL_STATS_EN.
module cache_repl_engine #(
    parameter int SETS  = 256,
    parameter int WAYS  = 4,
    parameter int SET_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input logic                clk,
    input logic                rst_n,
    cache_repl_engine_if.slave bus
);
    localparam int NODES  = WAYS - 1;
    localparam int AGES_W = WAYS * WAY_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state;
    logic [SET_W-1:0] init_ptr;
    logic             busy_q;
    logic             victim_valid_q;
    logic [WAY_W-1:0] victim_way_q;
    logic [15:0]      lfsr;
    logic             lfsr_fb;

    logic [NODES-1:0]  tree_mem [SETS];
    logic [AGES_W-1:0] age_mem  [SETS];

    logic              run;
    logic              acc_en;
    logic              req_en;
    logic [NODES-1:0]  v_tree;
    logic [NODES-1:0]  a_tree;
    logic [NODES-1:0]  new_tree;
    logic [AGES_W-1:0] v_ages;
    logic [AGES_W-1:0] a_ages;
    logic [AGES_W-1:0] new_ages;
    logic [AGES_W-1:0] init_ages;
    logic              inv_hit;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  plru_way;
    logic [WAY_W-1:0]  lru_way;
    logic [WAY_W-1:0]  sel_way;
    logic [WAY_W-1:0]  old_age;
    logic [WAY_W-1:0]  vnode;
    logic [WAY_W-1:0]  anode;

    assign run     = (state == ST_RUN);
    assign acc_en  = run && bus.access_valid;
    assign req_en  = run && bus.victim_req;
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Both ports read pre-update state; writes land at the clock edge.
    assign v_tree = tree_mem[bus.victim_set];
    assign v_ages = age_mem[bus.victim_set];
    assign a_tree = tree_mem[bus.access_set];
    assign a_ages = age_mem[bus.access_set];

    always_comb begin
        init_ages = '0;
        for (int i = 0; i < WAYS; i++) begin
            init_ages[i*WAY_W +: WAY_W] = WAY_W'(i);
        end
    end

    always_comb begin
        inv_hit = 1'b0;
        inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.valid_mask[i]) begin
                inv_hit = 1'b1;
                inv_way = WAY_W'(i);
            end
        end
        vnode    = '0;
        plru_way = '0;
        for (int l = 0; l < WAY_W; l++) begin
            plru_way[WAY_W-1-l] = v_tree[vnode];
            vnode = (vnode << 1) + WAY_W'(1) + WAY_W'(v_tree[vnode]);
        end
        lru_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (v_ages[i*WAY_W +: WAY_W] == WAY_W'(WAYS - 1)) begin
                lru_way = WAY_W'(i);
            end
        end
        sel_way = lfsr[WAY_W-1:0];
        unique case (1'b1)
            inv_hit: sel_way = inv_way;
            !inv_hit && bus.policy == 2'd1: sel_way = plru_way;
            !inv_hit && bus.policy == 2'd2: sel_way = lru_way;
            default: sel_way = lfsr[WAY_W-1:0];
        endcase
    end

    // Tree nodes on the path point away from the touched way.
    always_comb begin
        new_tree = a_tree;
        anode    = '0;
        for (int l = 0; l < WAY_W; l++) begin
            new_tree[anode] = ~bus.access_way[WAY_W-1-l];
            anode = (anode << 1) + WAY_W'(1)
                  + WAY_W'(bus.access_way[WAY_W-1-l]);
        end
        old_age = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (WAY_W'(i) == bus.access_way) begin
                old_age = a_ages[i*WAY_W +: WAY_W];
            end
        end
        new_ages = a_ages;
        for (int i = 0; i < WAYS; i++) begin
            if (WAY_W'(i) == bus.access_way) begin
                new_ages[i*WAY_W +: WAY_W] = '0;
            end else if (a_ages[i*WAY_W +: WAY_W] < old_age) begin
                new_ages[i*WAY_W +: WAY_W] =
                    a_ages[i*WAY_W +: WAY_W] + WAY_W'(1);
            end
        end
    end

    // State RAM has no reset; the init sweep gives it defined contents.
    always_ff @(posedge clk) begin
        if (!run) begin
            tree_mem[init_ptr] <= '0;
            age_mem[init_ptr]  <= init_ages;
        end else if (acc_en) begin
            tree_mem[bus.access_set] <= new_tree;
            age_mem[bus.access_set]  <= new_ages;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_INIT;
            init_ptr       <= '0;
            busy_q         <= 1'b1;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
            lfsr           <= 16'hACE1;
        end else begin
            victim_valid_q <= 1'b0;
            unique case (state)
                ST_INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == SET_W'(SETS - 1)) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    lfsr <= {lfsr[14:0], lfsr_fb};
                    if (req_en) begin
                        victim_valid_q <= 1'b1;
                        victim_way_q   <= sel_way;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_way   = victim_way_q;
    assign bus.busy         = busy_q;

`ifdef REPL_STATS_EN
    logic [31:0] acc_cnt;
    logic [31:0] vic_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
            vic_cnt <= '0;
        end else begin
            if (acc_en && acc_cnt != 32'hFFFF_FFFF) begin
                acc_cnt <= acc_cnt + 32'd1;
            end
            if (req_en && vic_cnt != 32'hFFFF_FFFF) begin
                vic_cnt <= vic_cnt + 32'd1;
            end
        end
    end

    assign bus.access_count = acc_cnt;
    assign bus.victim_count = vic_cnt;
`else
    assign bus.access_count = '0;
    assign bus.victim_count = '0;
`endif
endmodule

// File: tb/tb_cache_repl_engine.sv
// Self-checking bench for cache_repl_engine (SETS=256, WAYS=4).
// Reference model: recency lists for LRU, explicit tree for PLRU, LFSR steps.
module tb_cache_repl_engine;
    localparam int SETS = 256;
    localparam int WAYS = 4;
`ifdef REPL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    cache_repl_engine_if #(.SETS(SETS), .WAYS(WAYS)) bus ();

    cache_repl_engine #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int ord  [4][WAYS];
    int tree [4][WAYS-1];

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    function automatic int plru_pick(input int s);
        int n = 0;
        int w = 0;
        for (int l = 0; l < 2; l++) begin
            w = w * 2 + tree[s][n];
            n = 2 * n + 1 + tree[s][n];
        end
        return w;
    endfunction

    function automatic void model_touch(input int s, input int w);
        int idx = 0;
        int n = 0;
        int d;
        for (int i = 0; i < WAYS; i++) if (ord[s][i] == w) idx = i;
        for (int i = idx; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = w;
        for (int l = 0; l < 2; l++) begin
            d = (w >> (1 - l)) & 1;
            tree[s][n] = 1 - d;
            n = 2 * n + 1 + d;
        end
    endfunction

    task automatic idle();
        bus.policy       = 2'd0;
        bus.access_valid = 1'b0;
        bus.access_set   = '0;
        bus.access_way   = '0;
        bus.victim_req   = 1'b0;
        bus.victim_set   = '0;
        bus.valid_mask   = 4'hF;
    endtask

    task automatic access(input int s, input int w);
        bus.access_valid = 1'b1;
        bus.access_set   = 8'(s);
        bus.access_way   = 2'(w);
        @(negedge clk);
        bus.access_valid = 1'b0;
    endtask

    task automatic request(input int s, input logic [3:0] m,
                           output logic vv, output int w);
        bus.victim_req = 1'b1;
        bus.victim_set = 8'(s);
        bus.valid_mask = m;
        @(negedge clk);
        vv = bus.victim_valid;
        w  = int'(bus.victim_way);
        bus.victim_req = 1'b0;
        bus.valid_mask = 4'hF;
    endtask

    task automatic count_busy(output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (bus.busy === 1'b1 && n < 1000) begin
            if (bus.victim_valid !== 1'b0) seen = 1'b1;
            n++;
            @(negedge clk);
        end
        if (bus.victim_valid !== 1'b0) seen = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        bit seen;
        logic vv;
        int w;
        idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.victim_valid !== 1'b0 ||
            bus.victim_way !== 2'd0) begin
            fails++;
            $display("FAIL reset_outputs busy=%b vv=%b way=%0d want 1 0 0",
                     bus.busy, bus.victim_valid, bus.victim_way);
        end
        tests++;
        if (bus.access_count !== 32'd0 || bus.victim_count !== 32'd0) begin
            fails++;
            $display("FAIL reset_counters acc=%0d vic=%0d want 0 0",
                     bus.access_count, bus.victim_count);
        end
        rst_n = 1'b1;
        bus.policy       = 2'd2;
        bus.access_valid = 1'b1;
        bus.access_set   = 8'd5;
        bus.access_way   = 2'd3;
        bus.victim_req   = 1'b1;
        bus.victim_set   = 8'd5;
        count_busy(n, seen);
        bus.access_valid = 1'b0;
        bus.victim_req   = 1'b0;
        tests++;
        if (n != 256) begin
            fails++;
            $display("FAIL busy_cycles got %0d want 256", n);
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL busy_no_victim got victim_valid during busy want none");
        end
        request(5, 4'hF, vv, w);
        tests++;
        if (vv !== 1'b1 || w != 3) begin
            fails++;
            $display("FAIL first_lru vv=%b way=%0d want 1 3", vv, w);
        end
        @(negedge clk);
        tests++;
        if (bus.victim_valid !== 1'b0) begin
            fails++;
            $display("FAIL victim_pulse vv=%b want 0", bus.victim_valid);
        end
        tests++;
        if (bus.access_count !== 32'd0 ||
            bus.victim_count !== (STATS ? 32'd1 : 32'd0)) begin
            fails++;
            $display("FAIL counts_after_init acc=%0d vic=%0d want 0 %0d",
                     bus.access_count, bus.victim_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_invalid_priority();
        logic vv;
        int w;
        for (int p = 0; p < 3; p++) begin
            bus.policy = 2'(p);
            request(5, 4'b1011, vv, w);
            tests++;
            if (vv !== 1'b1 || w != 2) begin
                fails++;
                $display("FAIL invalid_1011 pol=%0d vv=%b way=%0d want 1 2",
                         p, vv, w);
            end
        end
        bus.policy = 2'(3);
        request(5, 4'b1110, vv, w);
        tests++;
        if (vv !== 1'b1 || w != 0) begin
            fails++;
            $display("FAIL invalid_1110 vv=%b way=%0d want 1 0", vv, w);
        end
    endtask

    task automatic test_lru_order();
        logic vv;
        int w;
        bus.policy = 2'd2;
        for (int i = 0; i < 4; i++) access(7, i);
        request(7, 4'hF, vv, w);
        tests++;
        if (vv !== 1'b1 || w != 0) begin
            fails++;
            $display("FAIL lru_after_0123 vv=%b way=%0d want 1 0", vv, w);
        end
        access(7, 0);
        request(7, 4'hF, vv, w);
        tests++;
        if (vv !== 1'b1 || w != 1) begin
            fails++;
            $display("FAIL lru_after_0 vv=%b way=%0d want 1 1", vv, w);
        end
    endtask

    task automatic test_plru();
        logic vv;
        int w;
        bus.policy = 2'd1;
        access(3, 0);
        access(3, 2);
        request(3, 4'hF, vv, w);
        tests++;
        if (vv !== 1'b1 || w != 1) begin
            fails++;
            $display("FAIL plru_set3 vv=%b way=%0d want 1 1", vv, w);
        end
        bus.policy = 2'd2;
        request(3, 4'hF, vv, w);
        tests++;
        if (vv !== 1'b1 || w != 3) begin
            fails++;
            $display("FAIL plru_then_lru vv=%b way=%0d want 1 3", vv, w);
        end
    endtask

    task automatic test_simultaneous();
        logic vv;
        int w;
        bus.policy       = 2'd2;
        bus.access_valid = 1'b1;
        bus.access_set   = 8'd9;
        bus.access_way   = 2'd3;
        bus.victim_req   = 1'b1;
        bus.victim_set   = 8'd9;
        bus.valid_mask   = 4'hF;
        @(negedge clk);
        bus.access_valid = 1'b0;
        bus.victim_req   = 1'b0;
        tests++;
        if (bus.victim_valid !== 1'b1 || bus.victim_way !== 2'd3) begin
            fails++;
            $display("FAIL same_cycle vv=%b way=%0d want 1 3",
                     bus.victim_valid, bus.victim_way);
        end
        request(9, 4'hF, vv, w);
        tests++;
        if (vv !== 1'b1 || w != 2) begin
            fails++;
            $display("FAIL after_same_cycle vv=%b way=%0d want 1 2", vv, w);
        end
    endtask

    task automatic test_random_reset();
        int n;
        bit seen;
        int hist [WAYS];
        logic [15:0] lf;
        int exp;
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_sweep_busy got %b want 1", bus.busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n, seen);
        tests++;
        if (n != 256 || seen) begin
            fails++;
            $display("FAIL restart_sweep cycles=%0d seen=%0b want 256 0", n, seen);
        end
        foreach (hist[i]) hist[i] = 0;
        lf = 16'hACE1;
        bus.policy     = 2'd0;
        bus.valid_mask = 4'hF;
        bus.victim_req = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            bus.victim_set = 8'($urandom_range(0, SETS - 1));
            @(negedge clk);
            exp = int'(lf[1:0]);
            tests++;
            if (bus.victim_valid !== 1'b1 || bus.victim_way !== 2'(exp)) begin
                fails++;
                $display("FAIL random_way req=%0d vv=%b way=%0d want 1 %0d",
                         i, bus.victim_valid, bus.victim_way, exp);
            end
            if (!$isunknown(bus.victim_way)) hist[int'(bus.victim_way)]++;
            lf = lfsr_step(lf);
        end
        tests++;
        if (bus.victim_count !== (STATS ? 32'd1024 : 32'd0) ||
            bus.access_count !== 32'd0) begin
            fails++;
            $display("FAIL random_counts vic=%0d acc=%0d want %0d 0",
                     bus.victim_count, bus.access_count, STATS ? 1024 : 0);
        end
        bus.victim_req = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            tests++;
            if (hist[i] < 200 || hist[i] > 312) begin
                fails++;
                $display("FAIL random_spread way=%0d count=%0d want 200..312",
                         i, hist[i]);
            end
        end
    endtask

    task automatic test_random_mix();
        int nacc = 0;
        bit do_acc, do_req;
        int as, aw, vs, pol, exp;
        logic [3:0] m;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < WAYS; i++) ord[s][i] = i;
            for (int i = 0; i < WAYS - 1; i++) tree[s][i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            do_acc = ($urandom_range(0, 1) == 1);
            do_req = ($urandom_range(0, 4) < 3);
            as  = $urandom_range(0, 3);
            aw  = $urandom_range(0, 3);
            vs  = $urandom_range(0, 3);
            pol = $urandom_range(1, 2);
            m   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            bus.policy       = 2'(pol);
            bus.access_valid = do_acc;
            bus.access_set   = 8'(16 + as);
            bus.access_way   = 2'(aw);
            bus.victim_req   = do_req;
            bus.victim_set   = 8'(16 + vs);
            bus.valid_mask   = m;
            exp = 0;
            if (m != 4'hF) begin
                exp = -1;
                for (int i = WAYS - 1; i >= 0; i--) if (!m[i]) exp = i;
            end else if (pol == 1) begin
                exp = plru_pick(vs);
            end else begin
                exp = ord[vs][WAYS-1];
            end
            @(negedge clk);
            tests++;
            if (do_req) begin
                if (bus.victim_valid !== 1'b1 || bus.victim_way !== 2'(exp)) begin
                    fails++;
                    $display("FAIL mix_victim cyc=%0d pol=%0d set=%0d mask=%b vv=%b way=%0d want 1 %0d",
                             c, pol, 16 + vs, m, bus.victim_valid,
                             bus.victim_way, exp);
                end
            end else if (bus.victim_valid !== 1'b0) begin
                fails++;
                $display("FAIL mix_idle cyc=%0d vv=%b want 0", c, bus.victim_valid);
            end
            if (do_acc) begin
                model_touch(as, aw);
                nacc++;
            end
        end
        idle();
        tests++;
        if (bus.access_count !== (STATS ? 32'(nacc) : 32'd0)) begin
            fails++;
            $display("FAIL mix_access_count got %0d want %0d",
                     bus.access_count, STATS ? nacc : 0);
        end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_invalid_priority();
        test_lru_order();
        test_plru();
        test_simultaneous();
        test_random_reset();
        test_random_mix();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_repl_engine.md
Name: cache_repl_engine

Overview:
- Parametrised replacement-policy unit for the L2 cache controller; generalises the fixed RANDOM/PLRU/LRU select into a standalone block.
- Per-set state for any power-of-two set count and associativity.
- The L2 controller reports every hit or fill through the access port and asks for a victim on a miss.
- Policy is selectable at run time. Invalid ways always take priority over the policy choice.

Parameters:
SETS, 256, number of sets (power of two, >=2)
WAYS, 4, associativity (2, 4 or 8)
SET_W, $clog2(SETS), set index width
WAY_W, $clog2(WAYS), way index width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
policy  in  2  0=RANDOM, 1=PLRU, 2=LRU, 3 treated as RANDOM
access_valid  in  1  hit/fill touched a way this cycle
access_set  in  SET_W  set of the touched way
access_way  in  WAY_W  touched way
victim_req  in  1  victim lookup request
victim_set  in  SET_W  set to choose a victim in
valid_mask  in  WAYS  line-valid bits of victim_set, sampled with victim_req
victim_valid  out  1  one-cycle pulse, victim_way valid
victim_way  out  WAY_W  chosen way
busy  out  1  init sweep in progress
access_count  out  32  saturating access count (REPL_STATS_EN)
victim_count  out  32  saturating victim count (REPL_STATS_EN)

Behaviour:
- Reset (async, rst_n=0):
  - victim_valid=0, victim_way=0, busy=1, counters=0.
  - LFSR=16'hACE1.
  - Init FSM enters INIT with set pointer 0.
- INIT state:
  - One set per cycle, for SETS cycles.
  - PLRU tree bits (WAYS-1 per set) written to 0.
  - LRU ages written as way i age=i.
  - After set SETS-1 is written: go to RUN, busy=0 on the next cycle.
  - rst_n asserted mid-sweep restarts the sweep from set 0.
- While busy: access_valid and victim_req are ignored; victim_valid stays 0.
- RUN state latency: victim_req sampled at edge N gives victim_valid=1 and victim_way for the whole of cycle N+1. Back-to-back requests are allowed, one result per cycle.
- Victim selection, in priority order:
  - If valid_mask is not all ones: the lowest-index way with a 0 bit, regardless of policy.
  - RANDOM: lfsr[WAY_W-1:0] at sample time.
  - PLRU: walk the tree from the root; bit 0 means go left, 1 means go right.
  - LRU: the way whose age is WAYS-1.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifting left.
  - Advances every RUN cycle, independent of requests.
- Access update:
  - Both PLRU and LRU state are updated on every access regardless of policy, so a mid-run policy change is consistent.
  - PLRU: each tree node on the path is set to point away from access_way.
  - LRU: access_way age becomes 0; each way with age less than the old age of access_way increments by 1; other ages are unchanged. Ages remain a permutation of 0..WAYS-1.
- Simultaneous access and victim_req on the same set: the victim is computed from pre-update state (read-before-write); the update commits at the same edge.
- A victim request does not modify replacement state. The controller reports the fill through the access port.
- Out-of-range inputs are not checked; behaviour for them is undefined.

Optional Feature:
REPL_STATS_EN
- Defined:
  - access_count increments on each accepted access.
  - victim_count increments on each victim_valid pulse.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Not defined:
  - Both ports are driven constant 0 and no counter flops exist.
  - All other behaviour is identical.

Test Plan:
1. Reset sweep (SETS=256, WAYS=4): release rst_n → busy=1 for exactly 256 cycles. A victim_req during busy gives no victim_valid. Afterwards, policy=LRU, set 5, mask 4'b1111 → victim_way=3 one cycle later.
2. Invalid priority: valid_mask=4'b1011 under each of the three policies → victim_way=2 every time. Mask 4'b1110 → way 0.
3. LRU order, set 7:
   - Access ways 0,1,2,3, then victim_req → way 0.
   - Access way 0, then victim_req → way 1.
4. PLRU, set 3 after reset: access way 0, then way 2, then victim_req → way 1. Switching to LRU for the same set → way 3.
5. Simultaneous events, LRU, set 9 fresh: access way 3 and victim_req in the same cycle → victim_way=3. The next request → way 2.
6. RANDOM plus reset mid-sweep:
   - Assert rst_n=0 at sweep cycle 100 → busy stays 1 for a full 256 cycles after release.
   - Then 1024 requests with mask all ones: victim_way matches the reference LFSR model every time, and each way is chosen 200–312 times.
   - With REPL_STATS_EN defined, victim_count=1024.
